branch_resolver: RTL and testbench

//  Execute-side counterpart of the fetch branch predictor. Queues each prediction made in fetch,

---
 rtl/branch_resolver.sv | 206 ++++++++++++++++++++
 tb/tb_branch_resolver.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// -----------------------------------------------------------------------------
// branch_resolver
//   Execute-side partner of the fetch branch predictor. Each prediction made in
//   fetch is queued here. When execute resolves the oldest branch, the queued
//   prediction is checked against the real outcome. A misprediction raises
//   miss / redirect and flushes the queue, because every younger entry is on
//   the wrong path. A BHT training update is sent back for every resolve.
//   Saturating branch and miss performance counters are also kept here.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   en                  pipeline enable (0 freezes all state, pulses forced 0)
//   push_*              prediction from fetch {pc, taken, target}
//   res_*               real outcome of the oldest queued branch
//   queue_full          queue holds DEPTH entries
//   busy                flush recovery in progress; fetch must not push
//   miss/redirect_*     1-cycle misprediction pulse and the correct next PC
//   update_*            1-cycle BHT training write (index, real direction)
//   overflow_err        sticky: push while full
//   underflow_err       sticky: resolve while empty
//   br_count/miss_count saturating performance counters
// -----------------------------------------------------------------------------
module branch_resolver #(
  parameter int DEPTH        = 4,
  parameter int INDEX_WIDTH  = 10,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   push_valid,
  input  logic [31:0]            push_pc,
  input  logic                   push_taken,
  input  logic [31:0]            push_target,
  input  logic                   res_valid,
  input  logic                   res_taken,
  input  logic [31:0]            res_target,
  output logic                   queue_full,
  output logic                   busy,
  output logic                   miss,
  output logic                   redirect_valid,
  output logic [31:0]            redirect_pc,
  output logic                   update_valid,
  output logic [INDEX_WIDTH-1:0] update_index,
  output logic                   update_taken,
  output logic                   overflow_err,
  output logic                   underflow_err,
  output logic [CNT_WIDTH-1:0]   br_count,
  output logic [CNT_WIDTH-1:0]   miss_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CQ_W  = $clog2(DEPTH + 1);
  localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Prediction storage
  logic [31:0] pc_mem     [DEPTH];
  logic        taken_mem  [DEPTH];
  logic [31:0] target_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CQ_W-1:0]  count;

  state_t           state_q, state_d;
  logic [FC_W-1:0]  cnt_q, cnt_d;

  logic miss_q, update_valid_q;

  // Head entry and decision terms
  logic [31:0] h_pc, h_target;
  logic        h_taken;
  logic        in_run;
  logic        resolve_req, push_req;
  logic        do_pop, do_push, mispredict, flush;
  logic        overflow_set, underflow_set;

  assign h_pc     = pc_mem[rd_ptr];
  assign h_taken  = taken_mem[rd_ptr];
  assign h_target = target_mem[rd_ptr];

  assign queue_full = (count == CQ_W'(DEPTH));
  assign in_run     = (state_q == ST_RUN);

  assign resolve_req = en & res_valid & in_run;
  assign push_req    = en & push_valid & in_run;

  assign do_pop     = resolve_req & (count != '0);
  assign mispredict = (h_taken != res_taken) | (res_taken & (h_target != res_target));
  assign flush      = do_pop & mispredict;

  // A same-cycle pop frees a slot, so a push into a full queue is legal then.
  // A push alongside a mispredicting resolve is wrong-path and simply dropped.
  assign do_push       = push_req & ~flush & (~queue_full | do_pop);
  assign overflow_set  = push_req & ~flush & queue_full & ~do_pop;
  assign underflow_set = resolve_req & (count == '0);

  // ---------------------------------------------------------------------------
  // Recovery FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (en) begin
      unique case (state_q)
        ST_RUN: begin
          if (flush) begin
            state_d = ST_FLUSH;
            cnt_d   = FC_W'(FLUSH_CYCLES - 1);
          end
        end
        ST_FLUSH: begin
          if (cnt_q == '0) state_d = ST_RUN;
          else             cnt_d   = cnt_q - FC_W'(1);
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  assign busy = (state_q == ST_FLUSH);

  // ---------------------------------------------------------------------------
  // Queue storage: data only, validity is carried by the pointers and count.
  // NOTE: the storage array is deliberately not reset; an entry is never read
  // before it has been written, and leaving it out of reset keeps it a plain RAM.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[wr_ptr]     <= push_pc;
      taken_mem[wr_ptr]  <= push_taken;
      target_mem[wr_ptr] <= push_target;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, count, result pulses, sticky errors and counters
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      miss_q         <= 1'b0;
      update_valid_q <= 1'b0;
      redirect_pc    <= '0;
      update_index   <= '0;
      update_taken   <= 1'b0;
      overflow_err   <= 1'b0;
      underflow_err  <= 1'b0;
      br_count       <= '0;
      miss_count     <= '0;
    end else begin
      // Pulses load 0 whenever there is no enabled resolve.
      miss_q         <= flush;
      update_valid_q <= do_pop;

      if (do_pop) begin
        update_index <= h_pc[INDEX_WIDTH+1:2];
        update_taken <= res_taken;
        redirect_pc  <= res_taken ? res_target : (h_pc + 32'd4);
        if (br_count != '1) br_count <= br_count + CNT_WIDTH'(1);
        if (flush && (miss_count != '1)) miss_count <= miss_count + CNT_WIDTH'(1);
      end

      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (do_push && !do_pop)      count <= count + CQ_W'(1);
        else if (do_pop && !do_push) count <= count - CQ_W'(1);
      end

      if (overflow_set)  overflow_err  <= 1'b1;
      if (underflow_set) underflow_err <= 1'b1;
    end
  end

  // Pulses are forced low while the pipeline is frozen.
  assign miss           = miss_q & en;
  assign redirect_valid = miss_q & en;
  assign update_valid   = update_valid_q & en;

endmodule

// File: tb/tb_branch_resolver.sv
// -----------------------------------------------------------------------------
// tb_branch_resolver
//   Directed testbench for branch_resolver with hand-computed expectations.
//   Inputs change 1 ns after a rising edge; outputs are checked at that point.
// -----------------------------------------------------------------------------
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        push_valid;
  logic [31:0] push_pc;
  logic        push_taken;
  logic [31:0] push_target;
  logic        res_valid;
  logic        res_taken;
  logic [31:0] res_target;
  logic        queue_full, busy, miss, redirect_valid, update_valid, update_taken;
  logic [31:0] redirect_pc;
  logic [9:0]  update_index;
  logic        overflow_err, underflow_err;
  logic [31:0] br_count, miss_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_resolver #(
    .DEPTH(4), .INDEX_WIDTH(10), .FLUSH_CYCLES(2), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .reset(reset), .en(en),
    .push_valid(push_valid), .push_pc(push_pc), .push_taken(push_taken),
    .push_target(push_target),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .queue_full(queue_full), .busy(busy), .miss(miss),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .update_valid(update_valid), .update_index(update_index),
    .update_taken(update_taken),
    .overflow_err(overflow_err), .underflow_err(underflow_err),
    .br_count(br_count), .miss_count(miss_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push_valid = 1'b0;
    res_valid  = 1'b0;
  endtask

  task automatic set_push(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    push_valid  = 1'b1;
    push_pc     = pc;
    push_taken  = tk;
    push_target = tg;
  endtask

  task automatic set_res(input logic tk, input logic [31:0] tg);
    res_valid  = 1'b1;
    res_taken  = tk;
    res_target = tg;
  endtask

  // One push cycle followed by an idle line
  task automatic push1(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    set_push(pc, tk, tg);
    cyc();
    idle();
  endtask

  initial begin
    reset = 1'b1; en = 1'b1;
    push_valid = 1'b0; push_pc = '0; push_taken = 1'b0; push_target = '0;
    res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
    cyc(); cyc();
    reset = 1'b0;

    // Reset state
    check("rst_busy",  {31'b0, busy}, 32'd0);
    check("rst_full",  {31'b0, queue_full}, 32'd0);
    check("rst_upd",   {31'b0, update_valid}, 32'd0);
    check("rst_miss",  {31'b0, miss}, 32'd0);
    check("rst_brcnt", br_count, 32'd0);
    check("rst_errs",  {30'b0, overflow_err, underflow_err}, 32'd0);

    // 1: correct taken prediction
    push1(32'h100, 1'b1, 32'h140);
    set_res(1'b1, 32'h140);
    cyc(); idle();
    check("t1_upd",   {31'b0, update_valid}, 32'd1);
    check("t1_idx",   {22'b0, update_index}, 32'h040);
    check("t1_taken", {31'b0, update_taken}, 32'd1);
    check("t1_miss",  {31'b0, miss}, 32'd0);
    check("t1_brcnt", br_count, 32'd1);
    cyc();
    check("t1_upd_pulse", {31'b0, update_valid}, 32'd0);

    // 2: predicted NT, really taken; pushes during the flush are ignored
    push1(32'h200, 1'b0, 32'h0);
    set_res(1'b1, 32'h260);
    cyc(); idle();
    check("t2_miss",   {31'b0, miss}, 32'd1);
    check("t2_redir",  {31'b0, redirect_valid}, 32'd1);
    check("t2_rpc",    redirect_pc, 32'h260);
    check("t2_busy0",  {31'b0, busy}, 32'd1);
    check("t2_mcnt",   miss_count, 32'd1);
    set_push(32'h280, 1'b0, 32'h0);
    cyc();
    check("t2_busy1",  {31'b0, busy}, 32'd1);
    check("t2_pulse",  {31'b0, miss}, 32'd0);
    cyc(); idle();
    check("t2_busy2",  {31'b0, busy}, 32'd0);
    check("t5_noovf",  {31'b0, overflow_err}, 32'd0);

    // 5: resolve with empty queue (flush-time pushes were dropped)
    set_res(1'b1, 32'h280);
    cyc(); idle();
    check("t5_noupd",  {31'b0, update_valid}, 32'd0);
    check("t5_nomiss", {31'b0, miss}, 32'd0);
    check("t5_undf",   {31'b0, underflow_err}, 32'd1);
    check("t5_brcnt",  br_count, 32'd2);

    // 3: predicted T, really NT, with three younger entries queued
    push1(32'h300, 1'b1, 32'h340);
    push1(32'h400, 1'b0, 32'h0);
    push1(32'h500, 1'b0, 32'h0);
    push1(32'h600, 1'b0, 32'h0);
    check("t3_full",   {31'b0, queue_full}, 32'd1);
    set_res(1'b0, 32'h0);
    cyc(); idle();
    check("t3_miss",   {31'b0, miss}, 32'd1);
    check("t3_rpc",    redirect_pc, 32'h304);
    check("t3_idx",    {22'b0, update_index}, 32'h0C0);
    check("t3_taken",  {31'b0, update_taken}, 32'd0);
    check("t3_nfull",  {31'b0, queue_full}, 32'd0);
    cyc(); cyc();
    check("t3_busy",   {31'b0, busy}, 32'd0);

    // 4: fill, push+pop while full, overflow, drain in order
    push1(32'h10, 1'b0, 32'h0);
    push1(32'h20, 1'b0, 32'h0);
    push1(32'h30, 1'b0, 32'h0);
    push1(32'h40, 1'b0, 32'h0);
    check("t4_full",   {31'b0, queue_full}, 32'd1);
    check("t4_noovf",  {31'b0, overflow_err}, 32'd0);
    set_push(32'h50, 1'b0, 32'h0);
    set_res(1'b0, 32'h0);
    cyc(); idle();
    check("t4_sim_idx",  {22'b0, update_index}, 32'h004);
    check("t4_sim_full", {31'b0, queue_full}, 32'd1);
    check("t4_sim_ovf",  {31'b0, overflow_err}, 32'd0);
    push1(32'h60, 1'b0, 32'h0);
    check("t4_ovf",    {31'b0, overflow_err}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      set_res(1'b0, 32'h0);
      cyc(); idle();
      check("t4_drain_upd",  {31'b0, update_valid}, 32'd1);
      check("t4_drain_idx",  {22'b0, update_index}, 32'(8 + 4 * i));
      check("t4_drain_miss", {31'b0, miss}, 32'd0);
    end
    check("t4_empty",  {31'b0, queue_full}, 32'd0);
    check("t4_brcnt",  br_count, 32'd8);
    check("t4_mcnt",   miss_count, 32'd2);
    set_res(1'b0, 32'h0);
    cyc(); idle();
    check("t4_drained", {31'b0, update_valid}, 32'd0);

    // 6: en=0 during flush freezes the counter
    push1(32'h700, 1'b1, 32'h740);
    set_res(1'b1, 32'h780);
    cyc(); idle();
    check("t6_miss",   {31'b0, miss}, 32'd1);
    check("t6_rpc",    redirect_pc, 32'h780);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t6_frz_busy", {31'b0, busy}, 32'd1);
      check("t6_frz_miss", {31'b0, miss}, 32'd0);
    end
    en = 1'b1;
    cyc();
    check("t6_busy_last", {31'b0, busy}, 32'd1);
    cyc();
    check("t6_busy_done", {31'b0, busy}, 32'd0);

    // 6b: reset in the middle of a flush
    push1(32'h800, 1'b0, 32'h0);
    push1(32'h900, 1'b0, 32'h0);
    set_res(1'b1, 32'hA00);
    cyc(); idle();
    check("t6_busy_pre", {31'b0, busy}, 32'd1);
    check("t6_mcnt",     miss_count, 32'd4);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("t6_rst_busy", {31'b0, busy}, 32'd0);
    check("t6_rst_mcnt", miss_count, 32'd0);
    check("t6_rst_errs", {30'b0, overflow_err, underflow_err}, 32'd0);
    set_res(1'b0, 32'h0);
    cyc(); idle();
    check("t6_rst_empty", {31'b0, update_valid}, 32'd0);
    check("t6_rst_undf",  {31'b0, underflow_err}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
